// File: rtl/acc_icb_bridge.sv
// acc_icb_bridge: ICB slave that fronts an accelerator's CTRL/STATUS
// registers and its three SRAM banks (IFM, WHT, RES). One outstanding
// transaction at a time. While the core is busy it owns the SRAM pins and
// bus SRAM accesses are stalled; register accesses are always served.
// Optional feature macro: ACC_ICB_ERR_EN. When defined, unmapped offsets and
// STATUS writes with wdata[1]=0 answer with icb_rsp_err=1.
module acc_icb_bridge #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RAW = 14,
  parameter logic [AW-1:0] BASE_ADDR = 32'h1010_0000,
  localparam int MW = DW / 8
) (
  input  logic           clk,
  input  logic           rst_n,
  // ICB command channel
  input  logic           icb_cmd_valid,
  output logic           icb_cmd_ready,
  input  logic           icb_cmd_read,
  input  logic [AW-1:0]  icb_cmd_addr,
  input  logic [DW-1:0]  icb_cmd_wdata,
  input  logic [MW-1:0]  icb_cmd_wmask,
  // ICB response channel
  output logic           icb_rsp_valid,
  input  logic           icb_rsp_ready,
  output logic           icb_rsp_err,
  output logic [DW-1:0]  icb_rsp_rdata,
  // core control / status
  output logic [DW-1:0]  ctrl_o,
  output logic           start_o,
  input  logic           core_busy_i,
  input  logic           core_done_i,
  // IFM bank
  output logic           ifm_cs,
  output logic           ifm_we,
  output logic [MW-1:0]  ifm_wem,
  output logic [RAW-1:0] ifm_addr,
  output logic [DW-1:0]  ifm_wdata,
  input  logic [DW-1:0]  ifm_rdata,
  input  logic           c_ifm_cs,
  input  logic           c_ifm_we,
  input  logic [MW-1:0]  c_ifm_wem,
  input  logic [RAW-1:0] c_ifm_addr,
  input  logic [DW-1:0]  c_ifm_wdata,
  // WHT bank
  output logic           wht_cs,
  output logic           wht_we,
  output logic [MW-1:0]  wht_wem,
  output logic [RAW-1:0] wht_addr,
  output logic [DW-1:0]  wht_wdata,
  input  logic [DW-1:0]  wht_rdata,
  input  logic           c_wht_cs,
  input  logic           c_wht_we,
  input  logic [MW-1:0]  c_wht_wem,
  input  logic [RAW-1:0] c_wht_addr,
  input  logic [DW-1:0]  c_wht_wdata,
  // RES bank
  output logic           res_cs,
  output logic           res_we,
  output logic [MW-1:0]  res_wem,
  output logic [RAW-1:0] res_addr,
  output logic [DW-1:0]  res_wdata,
  input  logic [DW-1:0]  res_rdata,
  input  logic           c_res_cs,
  input  logic           c_res_we,
  input  logic [MW-1:0]  c_res_wem,
  input  logic [RAW-1:0] c_res_addr,
  input  logic [DW-1:0]  c_res_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RDW  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [1:0] REG_REGION = 2'b00;
  localparam logic [1:0] IFM_REGION = 2'b01;
  localparam logic [1:0] WHT_REGION = 2'b10;
  localparam logic [1:0] RES_REGION = 2'b11;

  state_t state;
  state_t state_nxt;

  logic [19:0]    off;
  logic [1:0]     region;
  logic [RAW-1:0] word_addr;
  logic           in_win;
  logic           is_sram;
  logic           sel_ctrl;
  logic           sel_status;
  logic           sel_unmap;
  logic           accept;
  logic           done;
  logic [1:0]     rd_bank;
  logic [DW-1:0]  acc_rdata;
  logic           acc_err;
  logic [DW-1:0]  bank_rdata;
  logic           ctrl_wr;
  logic           status_clr;

  // Address decode of the current command.
  always_comb begin
    off        = icb_cmd_addr[19:0];
    region     = off[19:18];
    word_addr  = icb_cmd_addr[RAW+1:2];
    in_win     = (icb_cmd_addr[AW-1:20] == BASE_ADDR[AW-1:20]);
    is_sram    = (region != REG_REGION);
    sel_ctrl   = (off == 20'h00004);
    sel_status = (off == 20'h00008);
    sel_unmap  = !is_sram && !sel_ctrl && !sel_status;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: SRAM reads take an extra cycle for the synchronous read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (icb_cmd_read && is_sram) begin
            state_nxt = RDW;
          end else begin
            state_nxt = RSP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RDW: state_nxt = RSP;
      RSP: begin
        if (icb_rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RSP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: SRAM accesses stall while the core owns the banks.
  always_comb begin
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    case (state)
      IDLE:    icb_cmd_ready = in_win && !(is_sram && core_busy_i);
      RDW:     icb_rsp_valid = 1'b0;
      RSP:     icb_rsp_valid = 1'b1;
      default: icb_rsp_valid = 1'b0;
    endcase
  end

  assign accept     = icb_cmd_valid && icb_cmd_ready;
  assign ctrl_wr    = accept && sel_ctrl && !icb_cmd_read;
  assign status_clr = accept && sel_status && !icb_cmd_read && icb_cmd_wdata[1];

  // Bank pin mux: core when busy, otherwise the accepted bus command.
  always_comb begin
    ifm_cs = 1'b0;  ifm_we = 1'b0;  ifm_wem = {MW{1'b0}};
    ifm_addr = {RAW{1'b0}};  ifm_wdata = {DW{1'b0}};
    wht_cs = 1'b0;  wht_we = 1'b0;  wht_wem = {MW{1'b0}};
    wht_addr = {RAW{1'b0}};  wht_wdata = {DW{1'b0}};
    res_cs = 1'b0;  res_we = 1'b0;  res_wem = {MW{1'b0}};
    res_addr = {RAW{1'b0}};  res_wdata = {DW{1'b0}};
    if (core_busy_i) begin
      ifm_cs = c_ifm_cs;  ifm_we = c_ifm_we;  ifm_wem = c_ifm_wem;
      ifm_addr = c_ifm_addr;  ifm_wdata = c_ifm_wdata;
      wht_cs = c_wht_cs;  wht_we = c_wht_we;  wht_wem = c_wht_wem;
      wht_addr = c_wht_addr;  wht_wdata = c_wht_wdata;
      res_cs = c_res_cs;  res_we = c_res_we;  res_wem = c_res_wem;
      res_addr = c_res_addr;  res_wdata = c_res_wdata;
    end else begin
      ifm_cs = accept && (region == IFM_REGION);
      wht_cs = accept && (region == WHT_REGION);
      res_cs = accept && (region == RES_REGION);
      ifm_we = ifm_cs && !icb_cmd_read;
      wht_we = wht_cs && !icb_cmd_read;
      res_we = res_cs && !icb_cmd_read;
      ifm_wem = ifm_we ? icb_cmd_wmask : {MW{1'b0}};
      wht_wem = wht_we ? icb_cmd_wmask : {MW{1'b0}};
      res_wem = res_we ? icb_cmd_wmask : {MW{1'b0}};
      ifm_addr = ifm_cs ? word_addr : {RAW{1'b0}};
      wht_addr = wht_cs ? word_addr : {RAW{1'b0}};
      res_addr = res_cs ? word_addr : {RAW{1'b0}};
      ifm_wdata = ifm_we ? icb_cmd_wdata : {DW{1'b0}};
      wht_wdata = wht_we ? icb_cmd_wdata : {DW{1'b0}};
      res_wdata = res_we ? icb_cmd_wdata : {DW{1'b0}};
    end
  end

  // Immediate response data for register accesses and writes.
  always_comb begin
    acc_rdata = {DW{1'b0}};
    if (!icb_cmd_read || is_sram || sel_unmap) begin
      acc_rdata = {DW{1'b0}};
    end else if (sel_ctrl) begin
      acc_rdata = ctrl_o;
    end else begin
      acc_rdata = {{(DW-2){1'b0}}, done, core_busy_i};
    end
  end

  // Error flag for the accepted command.
  always_comb begin
`ifdef ACC_ICB_ERR_EN
    acc_err = sel_unmap || (sel_status && !icb_cmd_read && !icb_cmd_wdata[1]);
`else
    acc_err = 1'b0;
`endif
  end

  // Read-data select for the bank latched at accept.
  always_comb begin
    case (rd_bank)
      IFM_REGION: bank_rdata = ifm_rdata;
      WHT_REGION: bank_rdata = wht_rdata;
      RES_REGION: bank_rdata = res_rdata;
      default:    bank_rdata = {DW{1'b0}};
    endcase
  end

  // Response holding registers: loaded at accept, SRAM data loaded in RDW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb_rsp_rdata <= {DW{1'b0}};
      icb_rsp_err   <= 1'b0;
      rd_bank       <= 2'b00;
    end else if (accept) begin
      icb_rsp_rdata <= acc_rdata;
      icb_rsp_err   <= acc_err;
      rd_bank       <= region;
    end else if (state == RDW) begin
      icb_rsp_rdata <= bank_rdata;
    end else begin
      icb_rsp_rdata <= icb_rsp_rdata;
    end
  end

  // CTRL register with byte-mask update and start pulse on bit0 written as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_o  <= {DW{1'b0}};
      start_o <= 1'b0;
    end else begin
      start_o <= ctrl_wr && icb_cmd_wmask[0] && icb_cmd_wdata[0];
      if (ctrl_wr) begin
        for (int i = 0; i < MW; i++) begin
          if (icb_cmd_wmask[i]) begin
            ctrl_o[8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Sticky done flag; a done pulse beats a simultaneous W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (core_done_i) begin
      done <= 1'b1;
    end else if (status_clr) begin
      done <= 1'b0;
    end else begin
      done <= done;
    end
  end

endmodule

// File: tb/tb_acc_icb_bridge.sv
// Self-checking bench for acc_icb_bridge: directed scenarios plus a random
// transaction mix checked against a register/memory reference model.
module tb_acc_icb_bridge;

  localparam logic [31:0] BASE = 32'h1010_0000;
`ifdef ACC_ICB_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic icb_cmd_valid = 1'b0, icb_cmd_ready, icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_addr = 32'h0, icb_cmd_wdata = 32'h0;
  logic [3:0] icb_cmd_wmask = 4'h0;
  logic icb_rsp_valid, icb_rsp_ready = 1'b0, icb_rsp_err;
  logic [31:0] icb_rsp_rdata, ctrl_o;
  logic start_o, core_busy_i = 1'b0, core_done_i = 1'b0;
  logic ifm_cs, ifm_we, wht_cs, wht_we, res_cs, res_we;
  logic [3:0] ifm_wem, wht_wem, res_wem;
  logic [13:0] ifm_addr, wht_addr, res_addr;
  logic [31:0] ifm_wdata, wht_wdata, res_wdata;
  logic [31:0] ifm_rdata = 32'h0, wht_rdata = 32'h0, res_rdata = 32'h0;
  logic c_ifm_cs = 1'b0, c_ifm_we = 1'b0, c_wht_cs = 1'b0, c_wht_we = 1'b0, c_res_cs = 1'b0, c_res_we = 1'b0;
  logic [3:0] c_ifm_wem = 4'h0, c_wht_wem = 4'h0, c_res_wem = 4'h0;
  logic [13:0] c_ifm_addr = 14'h0, c_wht_addr = 14'h0, c_res_addr = 14'h0;
  logic [31:0] c_ifm_wdata = 32'h0, c_wht_wdata = 32'h0, c_res_wdata = 32'h0;

  int checks = 0;
  int passed = 0;
  int start_cnt = 0;

  // reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] ref_ctrl = 32'h0;
  bit ref_done = 1'b0;

  // SRAM contents
  logic [31:0] m_ifm [0:16383];
  logic [31:0] m_wht [0:16383];
  logic [31:0] m_res [0:16383];

  acc_icb_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata), .ctrl_o(ctrl_o), .start_o(start_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i),
    .ifm_cs(ifm_cs), .ifm_we(ifm_we), .ifm_wem(ifm_wem), .ifm_addr(ifm_addr), .ifm_wdata(ifm_wdata), .ifm_rdata(ifm_rdata),
    .c_ifm_cs(c_ifm_cs), .c_ifm_we(c_ifm_we), .c_ifm_wem(c_ifm_wem), .c_ifm_addr(c_ifm_addr), .c_ifm_wdata(c_ifm_wdata),
    .wht_cs(wht_cs), .wht_we(wht_we), .wht_wem(wht_wem), .wht_addr(wht_addr), .wht_wdata(wht_wdata), .wht_rdata(wht_rdata),
    .c_wht_cs(c_wht_cs), .c_wht_we(c_wht_we), .c_wht_wem(c_wht_wem), .c_wht_addr(c_wht_addr), .c_wht_wdata(c_wht_wdata),
    .res_cs(res_cs), .res_we(res_we), .res_wem(res_wem), .res_addr(res_addr), .res_wdata(res_wdata), .res_rdata(res_rdata),
    .c_res_cs(c_res_cs), .c_res_we(c_res_we), .c_res_wem(c_res_wem), .c_res_addr(c_res_addr), .c_res_wdata(c_res_wdata)
  );

  always #5 clk = ~clk;

  // synchronous SRAM models with byte write enables
  always @(posedge clk) begin
    if (ifm_cs) begin
      if (ifm_we) begin
        for (int i = 0; i < 4; i++) if (ifm_wem[i]) m_ifm[ifm_addr][8*i +: 8] <= ifm_wdata[8*i +: 8];
      end else ifm_rdata <= m_ifm[ifm_addr];
    end
    if (wht_cs) begin
      if (wht_we) begin
        for (int i = 0; i < 4; i++) if (wht_wem[i]) m_wht[wht_addr][8*i +: 8] <= wht_wdata[8*i +: 8];
      end else wht_rdata <= m_wht[wht_addr];
    end
    if (res_cs) begin
      if (res_we) begin
        for (int i = 0; i < 4; i++) if (res_wem[i]) m_res[res_addr][8*i +: 8] <= res_wdata[8*i +: 8];
      end else res_rdata <= m_res[res_addr];
    end
  end

  always @(negedge clk) if (start_o === 1'b1) start_cnt++;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Reference model: returns expected rdata/err/latency and updates state.
  function automatic void model_op(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [3:0] wm, input bit busy, input bit done_now,
                                   output logic [31:0] erd, output bit eerr, output int elat);
    int bank = int'(addr[19:18]);
    int key = bank * 65536 + int'(addr[15:2]);
    logic [19:0] off = addr[19:0];
    erd = 32'h0; eerr = 1'b0; elat = 1;
    if (bank != 0) begin
      if (rd) begin
        erd = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        elat = 2;
      end else begin
        ref_mem[key] = merge(ref_mem.exists(key) ? ref_mem[key] : 32'h0, wd, wm);
      end
    end else if (off == 20'h00004) begin
      if (rd) erd = ref_ctrl;
      else ref_ctrl = merge(ref_ctrl, wd, wm);
    end else if (off == 20'h00008) begin
      if (rd) erd = {30'h0, ref_done, busy};
      else if (wd[1]) ref_done = 1'b0;
      else eerr = ERR_ON;
    end else begin
      eerr = ERR_ON;
    end
    if (done_now) ref_done = 1'b1;
  endfunction

  // Bus driver: presents one command, waits for accept and response
  // (bounded), optionally stalls rsp_ready. Ends just after a negedge.
  task automatic do_cmd(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] wm, input int hold, input bit busy_rdw,
                        output logic [31:0] rdata, output bit err, output int lat,
                        output bit st1, output bit stable, output bit to);
    int n = 0;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm;
    to = 1'b0; stable = 1'b1; lat = 0; st1 = 1'b0; rdata = 32'h0; err = 1'b0;
    #1;
    while (icb_cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (icb_cmd_ready !== 1'b1) begin
      to = 1'b1; icb_cmd_valid = 1'b0; @(negedge clk); return;
    end
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0; lat = 1; st1 = start_o;
    if (busy_rdw) core_busy_i = 1'b1;
    while (icb_rsp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk); lat++;
    end
    if (icb_rsp_valid !== 1'b1) begin
      to = 1'b1; core_busy_i = 1'b0; return;
    end
    rdata = icb_rsp_rdata; err = icb_rsp_err;
    if (icb_cmd_ready !== 1'b0) stable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== rdata || icb_rsp_err !== err || icb_cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    icb_rsp_ready = 1'b0;
    if (busy_rdw) core_busy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    icb_cmd_addr = BASE | 32'h4;
    #1;
    checks++;
    if (icb_rsp_valid !== 1'b0 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== 32'h0 || ctrl_o !== 32'h0 || start_o !== 1'b0)
      $display("FAIL reset_outputs: valid=%b err=%b rdata=%h ctrl=%h start=%b, required all zero",
               icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, ctrl_o, start_o);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (icb_cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", icb_cmd_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_ctrl_start();
    logic [31:0] rd, erd; bit err, eerr, st1, stb, to; int lat, elat, s0;
    s0 = start_cnt;
    model_op(1'b0, BASE | 32'h4, 32'h0000_0001, 4'hF, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b0, BASE | 32'h4, 32'h0000_0001, 4'hF, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || lat != 1 || rd !== 32'h0 || st1 !== 1'b1)
      $display("FAIL ctrl_write: to=%b lat=%0d rdata=%h start=%b, required lat 1 rdata 0 start 1", to, lat, rd, st1);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt - s0 != 1) $display("FAIL start_pulse_len: got %0d cycles, required 1", start_cnt - s0);
    else passed++;
    model_op(1'b1, BASE | 32'h4, 32'h0, 4'h0, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b1, BASE | 32'h4, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'h1 || rd !== erd) $display("FAIL ctrl_readback: got %h, required %h", rd, 32'h1);
    else passed++;
    // byte0 masked off: upper bytes update, no start pulse
    s0 = start_cnt;
    model_op(1'b0, BASE | 32'h4, 32'hA5B6_C7FF, 4'hE, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b0, BASE | 32'h4, 32'hA5B6_C7FF, 4'hE, 0, 1'b0, rd, err, lat, st1, stb, to);
    do_cmd(1'b1, BASE | 32'h4, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'hA5B6_C701 || ctrl_o !== ref_ctrl || start_cnt != s0)
      $display("FAIL ctrl_mask: got %h ctrl=%h starts=%0d, required %h starts 0", rd, ctrl_o, start_cnt - s0, 32'hA5B6_C701);
    else passed++;
  endtask

  task automatic test_ifm_rw();
    logic [31:0] rd, erd; bit err, eerr, st1, stb, to; int lat, elat;
    model_op(1'b0, BASE | 32'h40010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, erd, eerr, elat);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = BASE | 32'h40010;
    icb_cmd_wdata = 32'hDEAD_BEEF; icb_cmd_wmask = 4'hF;
    #1;
    checks++;
    if (ifm_cs !== 1'b1 || ifm_we !== 1'b1 || ifm_addr !== 14'd4 || ifm_wem !== 4'hF || ifm_wdata !== 32'hDEAD_BEEF)
      $display("FAIL ifm_write_pins: cs=%b we=%b addr=%0d wem=%h wdata=%h, required 1 1 4 f deadbeef",
               ifm_cs, ifm_we, ifm_addr, ifm_wem, ifm_wdata);
    else passed++;
    icb_cmd_valid = 1'b0;
    do_cmd(1'b0, BASE | 32'h40010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, err, lat, st1, stb, to);
    model_op(1'b1, BASE | 32'h40010, 32'h0, 4'h0, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b1, BASE | 32'h40010, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || lat != 2 || rd !== 32'hDEAD_BEEF)
      $display("FAIL ifm_read: to=%b lat=%0d rdata=%h, required lat 2 rdata deadbeef", to, lat, rd);
    else passed++;
  endtask

  task automatic test_busy();
    logic [31:0] rd, erd; bit err, eerr, st1, stb, to; int lat, elat; bit bad = 1'b0;
    core_busy_i = 1'b1;
    c_wht_cs = 1'b1; c_wht_addr = 14'h123;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = BASE | 32'h80020;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (icb_cmd_ready !== 1'b0 || wht_cs !== 1'b1 || wht_addr !== 14'h123 || ifm_cs !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) $display("FAIL busy_stall: ready=%b wht_cs=%b wht_addr=%h, required 0 1 123", icb_cmd_ready, wht_cs, wht_addr);
    else passed++;
    icb_cmd_valid = 1'b0; c_wht_cs = 1'b0; c_wht_addr = 14'h0;
    model_op(1'b1, BASE | 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, erd, eerr, elat);
    do_cmd(1'b1, BASE | 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'h1 || rd !== erd) $display("FAIL busy_status: got %h to=%b, required %h", rd, to, 32'h1);
    else passed++;
    core_busy_i = 1'b0;
    // busy rising during the read-wait cycle still returns the bus data
    model_op(1'b0, BASE | 32'h80020, 32'h1234_5678, 4'hF, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b0, BASE | 32'h80020, 32'h1234_5678, 4'hF, 0, 1'b0, rd, err, lat, st1, stb, to);
    model_op(1'b1, BASE | 32'h80020, 32'h0, 4'h0, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b1, BASE | 32'h80020, 32'h0, 4'h0, 0, 1'b1, rd, err, lat, st1, stb, to);
    checks++;
    if (to || lat != 2 || rd !== erd) $display("FAIL busy_in_rdw: got %h lat=%0d, required %h lat 2", rd, lat, erd);
    else passed++;
  endtask

  task automatic test_done_w1c();
    logic [31:0] rd, erd; bit err, eerr, st1, stb, to; int lat, elat;
    core_done_i = 1'b1; @(negedge clk); core_done_i = 1'b0; ref_done = 1'b1;
    do_cmd(1'b1, BASE | 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'h2) $display("FAIL done_sticky: got %h, required %h", rd, 32'h2);
    else passed++;
    core_done_i = 1'b1;
    model_op(1'b0, BASE | 32'h8, 32'h2, 4'hF, 1'b0, 1'b1, erd, eerr, elat);
    do_cmd(1'b0, BASE | 32'h8, 32'h2, 4'hF, 0, 1'b0, rd, err, lat, st1, stb, to);
    core_done_i = 1'b0;
    do_cmd(1'b1, BASE | 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'h2 || ref_done !== 1'b1) $display("FAIL done_set_wins: got %h, required %h", rd, 32'h2);
    else passed++;
    model_op(1'b0, BASE | 32'h8, 32'h2, 4'hF, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b0, BASE | 32'h8, 32'h2, 4'hF, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || err !== 1'b0) $display("FAIL status_w1c_err: got %b, required 0", err);
    else passed++;
    do_cmd(1'b1, BASE | 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'h0) $display("FAIL done_clear: got %h, required %h", rd, 32'h0);
    else passed++;
  endtask

  task automatic test_rsp_hold();
    logic [31:0] rd, erd; bit err, eerr, st1, stb, to; int lat, elat;
    model_op(1'b1, BASE | 32'h40010, 32'h0, 4'h0, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b1, BASE | 32'h40010, 32'h0, 4'h0, 5, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || !stb || rd !== erd) $display("FAIL rsp_hold: stable=%b got %h, required stable 1 data %h", stb, rd, erd);
    else passed++;
  endtask

  task automatic test_err_and_window();
    logic [31:0] rd, erd; bit err, eerr, st1, stb, to; int lat, elat; bit bad = 1'b0;
    model_op(1'b1, BASE | 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b1, BASE | 32'h100, 32'h0, 4'h0, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || rd !== 32'h0 || err !== ERR_ON) $display("FAIL unmapped_read: rdata=%h err=%b, required 0 %b", rd, err, ERR_ON);
    else passed++;
    model_op(1'b0, BASE | 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, erd, eerr, elat);
    do_cmd(1'b0, BASE | 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, err, lat, st1, stb, to);
    checks++;
    if (to || err !== ERR_ON) $display("FAIL status_w0_err: got %b, required %b", err, ERR_ON);
    else passed++;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h2010_0004;
    for (int i = 0; i < 3; i++) begin
      #1; if (icb_cmd_ready !== 1'b0) bad = 1'b1; @(negedge clk);
    end
    icb_cmd_valid = 1'b0;
    checks++;
    if (bad) $display("FAIL out_of_window: ready seen 1, required 0");
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic [3:0] wm; bit err, eerr, st1, stb, to, r;
    int lat, elat, kind, hold; logic [19:0] off;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      r = 1'($urandom_range(0, 1));
      wd = $urandom; wm = 4'($urandom_range(0, 15));
      case (kind)
        0: off = 20'h00004;
        1: off = 20'h00008;
        2: begin
          off = 20'($urandom_range(0, 32'h3FFFF)) & 20'hFFFFC;
          if (off == 20'h00004 || off == 20'h00008) off = 20'h00100;
        end
        default: off = {2'(kind - 2), 2'($urandom_range(0, 3)), 14'($urandom_range(0, 15)), 2'b00};
      endcase
      addr = BASE | {12'h0, off};
      hold = $urandom_range(0, 2);
      model_op(r, addr, wd, wm, 1'b0, 1'b0, erd, eerr, elat);
      do_cmd(r, addr, wd, wm, hold, 1'b0, rd, err, lat, st1, stb, to);
      checks++;
      if (to || rd !== erd || err !== eerr || lat != elat || !stb)
        $display("FAIL random_%0d: rd=%b addr=%h got rdata=%h err=%b lat=%0d stable=%b to=%b, required rdata=%h err=%b lat=%0d",
                 n, r, addr, rd, err, lat, stb, to, erd, eerr, elat);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = BASE | 32'h4;
    icb_cmd_wdata = 32'h0000_0055; icb_cmd_wmask = 4'hF;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0; rst_n = 1'b0;
    #1;
    ref_ctrl = 32'h0; ref_done = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (icb_rsp_valid !== 1'b0 || ctrl_o !== 32'h0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) $display("FAIL reset_mid: valid=%b ctrl=%h, required 0 0", icb_rsp_valid, ctrl_o);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      m_ifm[i] = 32'h0; m_wht[i] = 32'h0; m_res[i] = 32'h0;
    end
    test_reset();
    test_ctrl_start();
    test_ifm_rw();
    test_busy();
    test_done_w1c();
    test_rsp_hold();
    test_err_and_window();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
